// File: rtl/regfile_pkg.sv
// Shared constants for the register file write arbiter: geometry and requester indices.
// Requester A (ALU result) and B (memory load) index the arbiter's req/grant vectors.
package regfile_pkg;
    localparam int WIDTH = 24;
    localparam int SIZE  = 8;
    localparam int AW    = $clog2(SIZE);
    localparam int REQ_A = 0;
    localparam int REQ_B = 1;
endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: grant is combinational from req and the last-winner pointer.
// Latency 0 cycles; no backpressure of its own, an idle cycle leaves the pointer unchanged.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_b;

    always_comb begin
        grant = '0;
        if (req[REQ_A] && req[REQ_B]) begin
            // The side that did not win last time takes the conflict.
            if (last_b) grant[REQ_A] = 1'b1;
            else        grant[REQ_B] = 1'b1;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_b <= 1'b1;
        else if (|grant) last_b <= grant[REQ_B];
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter + scoreboard; forwarding enabled by `REGFILE_ARB_FWD_EN.
// Latency: accept at edge N -> write pulse in cycle N+1; hazard/fwd/ready are combinational.
// Backpressure: output stage always drains; only the arbitration loser sees ready=0.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH = regfile_pkg::WIDTH,
    parameter int SIZE  = regfile_pkg::SIZE,
    parameter int AW    = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reqA_valid,
    input  logic [AW-1:0]    reqA_addr,
    input  logic [WIDTH-1:0] reqA_data,
    output logic             reqA_ready,
    input  logic             reqB_valid,
    input  logic [AW-1:0]    reqB_addr,
    input  logic [WIDTH-1:0] reqB_data,
    output logic             reqB_ready,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    rdAddrA,
    input  logic [AW-1:0]    rdAddrB,
    output logic             hazard,
    output logic             fwdA,
    output logic             fwdB,
    output logic             write,
    output logic [AW-1:0]    wrAddr,
    output logic [WIDTH-1:0] wrData,
    output logic [SIZE-1:0]  pending
);

    logic [1:0]      grant;
    logic [SIZE-1:0] pending_nxt;
    logic            hz_a;
    logic            hz_b;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({reqB_valid, reqA_valid}),
        .grant (grant)
    );

    assign reqA_ready = grant[REQ_A];
    assign reqB_ready = grant[REQ_B];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write  <= 1'b0;
            wrAddr <= '0;
            wrData <= '0;
        end else begin
            write <= |grant;
            if (grant[REQ_A]) begin
                wrAddr <= reqA_addr;
                wrData <= reqA_data;
            end else if (grant[REQ_B]) begin
                wrAddr <= reqB_addr;
                wrData <= reqB_data;
            end
        end
    end

    // Clear first, then set, so a reserve on the writeback edge keeps the bit.
    always_comb begin
        pending_nxt = pending;
        if (write)     pending_nxt[wrAddr]   = 1'b0;
        if (rsv_valid) pending_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

`ifdef REGFILE_ARB_FWD_EN
    assign fwdA = write && (wrAddr == rdAddrA);
    assign fwdB = write && (wrAddr == rdAddrB);
`else
    assign fwdA = 1'b0;
    assign fwdB = 1'b0;
`endif

    assign hz_a   = pending[rdAddrA] && !fwdA;
    assign hz_b   = pending[rdAddrB] && !fwdB;
    assign hazard = hz_a || hz_b;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: constant vector table, directed corner sequences, and
// random traffic against a queue-free reference model of arbitration and the scoreboard.
module tb_regfile_wr_arbiter;

`ifdef REGFILE_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        reqA_valid, reqB_valid, reqA_ready, reqB_ready;
    logic [2:0]  reqA_addr, reqB_addr;
    logic [23:0] reqA_data, reqB_data;
    logic        rsv_valid;
    logic [2:0]  rsv_addr, rdAddrA, rdAddrB;
    logic        hazard, fwdA, fwdB, write;
    logic [2:0]  wrAddr;
    logic [23:0] wrData;
    logic [7:0]  pending;

    always #5 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .reqA_valid(reqA_valid), .reqA_addr(reqA_addr), .reqA_data(reqA_data), .reqA_ready(reqA_ready),
        .reqB_valid(reqB_valid), .reqB_addr(reqB_addr), .reqB_data(reqB_data), .reqB_ready(reqB_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
        .hazard(hazard), .fwdA(fwdA), .fwdB(fwdB),
        .write(write), .wrAddr(wrAddr), .wrData(wrData), .pending(pending)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: per-register pending flags, last winner, register-file port.
    bit          m_pend [8];
    bit          m_last_is_b;
    bit          m_w;
    int          m_addr;
    logic [23:0] m_data;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last_is_b = 1'b1;
        m_w = 1'b0;
        m_addr = 0;
        m_data = '0;
    endtask

    function automatic bit exp_grant_a();
        if (reqA_valid && reqB_valid) return m_last_is_b;
        return reqA_valid;
    endfunction

    function automatic bit exp_grant_b();
        return reqB_valid && !exp_grant_a();
    endfunction

    function automatic bit exp_fwd(input int src);
        return FWD && m_w && (m_addr == src);
    endfunction

    function automatic bit exp_hazard();
        bit ha, hb;
        ha = m_pend[int'(rdAddrA)] && !exp_fwd(int'(rdAddrA));
        hb = m_pend[int'(rdAddrB)] && !exp_fwd(int'(rdAddrB));
        return ha || hb;
    endfunction

    function automatic logic [7:0] exp_pending();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check_all();
        cmp("readyA", 32'(reqA_ready), 32'(exp_grant_a()));
        cmp("readyB", 32'(reqB_ready), 32'(exp_grant_b()));
        cmp("hazard", 32'(hazard), 32'(exp_hazard()));
        cmp("fwdA", 32'(fwdA), 32'(exp_fwd(int'(rdAddrA))));
        cmp("fwdB", 32'(fwdB), 32'(exp_fwd(int'(rdAddrB))));
        cmp("write", 32'(write), 32'(m_w));
        cmp("wrAddr", 32'(wrAddr), 32'(m_addr));
        cmp("wrData", 32'(wrData), 32'(m_data));
        cmp("pending", 32'(pending), 32'(exp_pending()));
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit ga, gb;
        ga = exp_grant_a();
        gb = exp_grant_b();
        if (m_w) m_pend[m_addr] = 1'b0;
        if (rsv_valid) m_pend[int'(rsv_addr)] = 1'b1;
        m_w = ga || gb;
        if (ga) begin m_addr = int'(reqA_addr); m_data = reqA_data; end
        else if (gb) begin m_addr = int'(reqB_addr); m_data = reqB_data; end
        if (ga || gb) m_last_is_b = gb;
    endtask

    task automatic cyc();
        #4;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reqA_valid = 0; reqB_valid = 0; rsv_valid = 0;
    endtask

    typedef struct {
        logic        va; logic [2:0] aa; logic [23:0] da;
        logic        vb; logic [2:0] ab; logic [23:0] db;
        logic        rv; logic [2:0] ra;
        logic        era, erb;
        logic        ew; logic [2:0] eaddr; logic [23:0] edata; logic [7:0] epend;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1, 3, 24'h00ABCD, 0, 0, 24'h0,      0, 0, 1, 0, 1, 3, 24'h00ABCD, 8'h00};
        vecs[1]  = '{0, 0, 24'h0,      0, 0, 24'h0,      0, 0, 0, 0, 0, 3, 24'h00ABCD, 8'h00};
        vecs[2]  = '{1, 1, 24'h111111, 1, 2, 24'h222222, 0, 0, 0, 1, 1, 2, 24'h222222, 8'h00};
        vecs[3]  = '{1, 1, 24'h111111, 1, 4, 24'h444444, 0, 0, 1, 0, 1, 1, 24'h111111, 8'h00};
        vecs[4]  = '{1, 5, 24'h555555, 1, 4, 24'h444444, 0, 0, 0, 1, 1, 4, 24'h444444, 8'h00};
        vecs[5]  = '{1, 5, 24'h555555, 1, 6, 24'h666666, 0, 0, 1, 0, 1, 5, 24'h555555, 8'h00};
        vecs[6]  = '{0, 0, 24'h0,      1, 6, 24'h666666, 1, 5, 0, 1, 1, 6, 24'h666666, 8'h20};
        vecs[7]  = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 2, 0, 0, 0, 6, 24'h666666, 8'h24};
        vecs[8]  = '{1, 5, 24'h0A0A0A, 0, 0, 24'h0,      0, 0, 1, 0, 1, 5, 24'h0A0A0A, 8'h24};
        vecs[9]  = '{0, 0, 24'h0,      0, 0, 24'h0,      0, 0, 0, 0, 0, 5, 24'h0A0A0A, 8'h04};
        vecs[10] = '{1, 2, 24'h0BBBBB, 0, 0, 24'h0,      0, 0, 1, 0, 1, 2, 24'h0BBBBB, 8'h04};
        vecs[11] = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 2, 0, 0, 0, 2, 24'h0BBBBB, 8'h04};
        vecs[12] = '{0, 0, 24'h0,      0, 0, 24'h0,      0, 0, 0, 0, 0, 2, 24'h0BBBBB, 8'h04};

        rst = 1'b1;
        idle();
        reqA_addr = 0; reqA_data = 0; reqB_addr = 0; reqB_data = 0;
        rsv_addr = 0; rdAddrA = 0; rdAddrB = 0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: single requester, contention alternation, reserve/clear, set-wins collision.
        for (int i = 0; i < 13; i++) begin
            reqA_valid = vecs[i].va; reqA_addr = vecs[i].aa; reqA_data = vecs[i].da;
            reqB_valid = vecs[i].vb; reqB_addr = vecs[i].ab; reqB_data = vecs[i].db;
            rsv_valid  = vecs[i].rv; rsv_addr  = vecs[i].ra;
            #4;
            cmp($sformatf("tbl%0d_readyA", i), 32'(reqA_ready), 32'(vecs[i].era));
            cmp($sformatf("tbl%0d_readyB", i), 32'(reqB_ready), 32'(vecs[i].erb));
            check_all();
            model_edge();
            @(posedge clk);
            #1;
            cmp($sformatf("tbl%0d_write", i), 32'(write), 32'(vecs[i].ew));
            cmp($sformatf("tbl%0d_wrAddr", i), 32'(wrAddr), 32'(vecs[i].eaddr));
            cmp($sformatf("tbl%0d_wrData", i), 32'(wrData), 32'(vecs[i].edata));
            cmp($sformatf("tbl%0d_pending", i), 32'(pending), 32'(vecs[i].epend));
        end
        idle();

        // Hazard on r5: reserve, read, writeback, then clear.
        rsv_valid = 1; rsv_addr = 5; rdAddrA = 5;
        cyc();
        rsv_valid = 0;
        #4; cmp("hz_reserved", 32'(hazard), 32'd1); #1; @(posedge clk); #1;
        // the model saw no edge above; catch it up (inputs were idle)
        model_edge();
        reqA_valid = 1; reqA_addr = 5; reqA_data = 24'h00C0DE;
        #4; cmp("hz_accept_cycle", 32'(hazard), 32'd1);
        check_all(); model_edge(); @(posedge clk); #1;
        idle();
        #4; cmp("hz_write_cycle", 32'(hazard), 32'(!FWD));
        cmp("fwdA_write_cycle", 32'(fwdA), 32'(FWD));
        check_all(); model_edge(); @(posedge clk); #1;
        #4; cmp("hz_after_write", 32'(hazard), 32'd0);
        cmp("pending5_cleared", 32'(pending[5]), 32'd0);
        check_all(); model_edge(); @(posedge clk); #1;

        // Forwarding on r7 through source B.
        rdAddrA = 0; rsv_valid = 1; rsv_addr = 7;
        cyc();
        rsv_valid = 0; reqA_valid = 1; reqA_addr = 7; reqA_data = 24'h777777; rdAddrB = 7;
        cyc();
        idle();
        #4; cmp("fwdB_r7", 32'(fwdB), 32'(FWD));
        cmp("hz_r7", 32'(hazard), 32'(!FWD));
        check_all(); model_edge(); @(posedge clk); #1;
        rdAddrB = 0;

        // Reset mid-write with every register pending.
        for (int i = 0; i < 8; i++) begin
            rsv_valid = 1; rsv_addr = 3'(i);
            cyc();
        end
        rsv_valid = 0; reqA_valid = 1; reqA_addr = 6; reqA_data = 24'h5A5A5A;
        cyc();
        idle();
        cmp("pre_rst_pending", 32'(pending), 32'hFF);
        cmp("pre_rst_write", 32'(write), 32'd1);
        #2; rst = 1'b1;
        #1;
        cmp("rst_write", 32'(write), 32'd0);
        cmp("rst_pending", 32'(pending), 32'd0);
        cmp("rst_wrAddr", 32'(wrAddr), 32'd0);
        cmp("rst_wrData", 32'(wrData), 32'd0);
        model_reset();
        rst = 1'b0;
        reqA_valid = 1; reqA_addr = 1; reqA_data = 24'h0000A1;
        reqB_valid = 1; reqB_addr = 2; reqB_data = 24'h0000B2;
        #1;
        cmp("post_rst_readyA", 32'(reqA_ready), 32'd1);
        cmp("post_rst_readyB", 32'(reqB_ready), 32'd0);
        check_all(); model_edge(); @(posedge clk); #1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reqA_valid = 1'($urandom_range(0, 1));
            reqA_addr  = 3'($urandom_range(0, 7));
            reqA_data  = 24'($urandom);
            reqB_valid = 1'($urandom_range(0, 1));
            reqB_addr  = 3'($urandom_range(0, 7));
            reqB_data  = 24'($urandom);
            rsv_valid  = ($urandom_range(0, 3) == 0);
            rsv_addr   = 3'($urandom_range(0, 7));
            rdAddrA    = 3'($urandom_range(0, 7));
            rdAddrB    = 3'($urandom_range(0, 7));
            cyc();
        end
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and scoreboard for the register file unit (WIDTH 24, SIZE 8). Two writeback requesters (A: ALU result, B: memory load) share the single register file write port via round-robin arbitration. The block registers the granted write onto the `write`/`wrAddr`/`wrData` port and tracks a per-register pending bit set at issue and cleared at writeback. From that bit it reports read hazards for the issue stage's two source addresses.

## Interface
- `WIDTH`, 24, data width; matches the register file.
- `SIZE`, 8, number of registers; AW = $clog2(SIZE).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `reqA_valid` / `reqB_valid`  in  1  writeback request.
- `reqA_addr` / `reqB_addr`  in  AW  destination register.
- `reqA_data` / `reqB_data`  in  WIDTH  write data.
- `reqA_ready` / `reqB_ready`  out  1  grant; the request is accepted on an edge where valid && ready.
- `rsv_valid`  in  1  issue stage reserves a destination register.
- `rsv_addr`  in  AW  register to reserve.
- `rdAddrA` / `rdAddrB`  in  AW  issue stage source registers.
- `hazard`  out  1  a source register is pending and not forwardable.
- `fwdA` / `fwdB`  out  1  source matches the write in flight; consumer takes `wrData`.
- `write`  out  1  register file write enable, one-cycle pulse.
- `wrAddr`  out  AW  register file write address.
- `wrData`  out  WIDTH  register file write data.
- `pending`  out  SIZE  scoreboard vector; bit i is pending for register i.

## Operation
- Arbitration:
  - Combinational; at most one grant per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, grant goes to the requester that did not win the last contested or uncontested grant.
  - The last-grant pointer resets to B, so A wins the first conflict.
  - `ready` never depends on `ready`; it depends only on the valid inputs and the pointer.
- Output stage:
  - Always drains, so no backpressure beyond the arbiter.
  - An accepted request is registered to `write`=1, `wrAddr`, `wrData` for exactly one cycle.
  - With no accept, `write`=0 and `wrAddr`/`wrData` hold their values.
- Scoreboard:
  - `rsv_valid` sets `pending[rsv_addr]`.
  - `write`=1 clears `pending[wrAddr]` at the end of that cycle.
  - If a set and a clear hit the same register on the same edge, the set wins.
  - Reserving an already-pending register leaves it set.
  - Writing a non-pending register is legal and leaves the scoreboard unchanged.
- Hazard: for each source X in {A, B}, `hzX` = `pending[rdAddrX]` and not forwardable; `hazard` = hzA | hzB.
- Reset (asynchronous, including mid-operation):
  - `pending`=0, `write`=0, `wrAddr`=0, `wrData`=0, pointer=B.
  - `ready` then reflects the valid inputs combinationally.
  - An in-flight write is dropped.

## Timing
- Request accepted at edge N → `write`=1 during cycle N+1 → register file captures at edge N+1 → `pending` bit clears at edge N+1.
- Minimum request-to-readable latency is 2 edges; 1 cycle when forwarded.
- Sustained throughput: one write per cycle.
- `hazard`, `fwdA`, `fwdB` and `ready` are combinational from the inputs and registered state, with zero cycles of latency.
- A reserve at edge M makes `hazard` visible from cycle M+1.

## Configuration
- `REGFILE_ARB_FWD_EN` defined:
  - `fwdX` = `write` && `wrAddr`==`rdAddrX`.
  - A pending source matching the in-flight write is not a hazard.
- Not defined:
  - `fwdA`/`fwdB` tied to 0.
  - `hazard` stays asserted during cycle N+1 and drops in N+2.

## Structure
- Package `regfile_pkg`:
  - WIDTH/SIZE defaults.
  - AW helper constant.
  - Requester index constants (REQ_A=0, REQ_B=1).
- Sub-module `rr_arb2`: two-way round-robin arbiter with pointer register, inputs `clk`/`rst`/req[1:0], output grant[1:0].
- Scoreboard and output register live in the top module.

## Test plan
- Reset: assert `rst` mid-write with `pending`=8'hFF → immediately `write`=0, `pending`=0, `wrAddr`=0; first conflict after release grants A.
- Single requester:
  - Stimulus: A writes r3=24'h00ABCD at edge N.
  - Expect: `write`=1, `wrAddr`=3, `wrData`=24'h00ABCD in cycle N+1 only.
- Contention: A and B valid every cycle for 4 cycles → grants A, B, A, B; the loser holds data and is accepted the next cycle.
- Scoreboard hazard:
  - Stimulus: reserve r5, then `rdAddrA`=5, then writeback r5.
  - Expect: `hazard`=1 until the write cycle, 0 in the cycle after the write, `pending[5]`=0.
- Set/clear collision: `write` r2 in flight and `rsv_valid` r2 on the same edge → `pending[2]` remains 1.
- Forwarding:
  - With `REGFILE_ARB_FWD_EN`, pending r7 and `write`=1 to r7, `rdAddrB`=7 → `fwdB`=1, `hazard`=0.
  - Without the macro, the same stimulus gives `fwdB`=0, `hazard`=1.
